// File: rtl/intc_cpu_if.sv
// CPU-side interrupt presenter: holds one selected interrupt toward the CPU and
// sequences the acknowledge. Optional preemption under `INTC_CPU_IF_PREEMPT_EN.
module intc_cpu_if #(
    parameter int unsigned GUARD_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sl_req_i,
    input  logic [4:0] sl_level_i,
    input  logic [7:0] sl_vec_i,
    input  logic [3:0] cpu_imask_i,
    input  logic       cpu_ack_i,
    output logic       cpu_int_o,
    output logic [4:0] cpu_level_o,
    output logic [7:0] cpu_vec_o,
    output logic       cp_intack_all_o,
    output logic       ack_pulse_o,
    output logic [7:0] ack_vec_o,
    output logic       spur_ack_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_GUARD} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] lvl_q, lvl_d;
    logic [7:0] vec_q, vec_d;
    logic       int_q, iack_q, apulse_q, spur_q;
    logic [7:0] avec_q;
    logic       elig;

    // Level 16 exceeds any 4-bit mask, so NMI/ERR is always eligible.
    assign elig = sl_req_i && (sl_level_i > {1'b0, cpu_imask_i});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        vec_d   = vec_q;
        unique case (state_q)
            S_IDLE: begin
                if (elig) begin
                    state_d = S_REQ;
                    lvl_d   = sl_level_i;
                    vec_d   = sl_vec_i;
                end
            end
            S_REQ: begin
                if (cpu_ack_i) begin
                    state_d = S_ACK;
                end else if (!elig) begin
                    state_d = S_IDLE;
`ifdef INTC_CPU_IF_PREEMPT_EN
                end else if (sl_level_i > lvl_q) begin
                    lvl_d = sl_level_i;
                    vec_d = sl_vec_i;
`endif
                end
            end
            S_ACK: begin
                state_d = S_GUARD;
                cnt_d   = 4'(GUARD_CYC);
            end
            S_GUARD: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            lvl_q    <= 5'd0;
            vec_q    <= 8'd0;
            int_q    <= 1'b0;
            iack_q   <= 1'b0;
            apulse_q <= 1'b0;
            avec_q   <= 8'd0;
            spur_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lvl_q    <= lvl_d;
            vec_q    <= vec_d;
            int_q    <= (state_d == S_REQ);
            iack_q   <= (state_d == S_ACK) || (state_d == S_GUARD);
            apulse_q <= (state_d == S_ACK);
            avec_q   <= (state_d == S_ACK) ? vec_q : 8'd0;
            spur_q   <= cpu_ack_i && (state_q != S_REQ);
        end
    end

    assign cpu_int_o       = int_q;
    assign cpu_level_o     = lvl_q;
    assign cpu_vec_o       = vec_q;
    assign cp_intack_all_o = iack_q;
    assign ack_pulse_o     = apulse_q;
    assign ack_vec_o       = avec_q;
    assign spur_ack_o      = spur_q;
endmodule
